sb_event_collector: RTL and testbench
=====================================

# sb_event_collector

Collects event words from the five child instances of an `sb8`-level hierarchy node and serializes them toward the parent. It sits directly downstream of the five-instance node and is the single point through which child activity reaches the level above. Children present events on independent valid/ready channels. A round-robin arbiter grants one child per cycle into a small FIFO, and the FIFO drains to the parent over a valid/ready channel tagged with the source child index.

## Interface
Parameters:
- `N_CHILD`, 5, number of child channels (2..16)
- `DATA_W`, 16, event payload width
- `FIFO_DEPTH`, 4, FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `child_valid`  in  N_CHILD  per-child event valid
- `child_data`  in  N_CHILD*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W]
- `child_ready`  out  N_CHILD  one-hot grant; all zero when no grant
- `evt_valid`  out  1  FIFO head valid
- `evt_ready`  in  1  parent accepts head
- `evt_data`  out  DATA_W  head payload
- `evt_src`  out  SRC_W  head source index; SRC_W = max(1, $clog2(N_CHILD))
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `evt_count`  out  16  events delivered to parent; present only with EVT_COUNT_EN

## Operation
- Arbiter:
  - Register `rr_ptr` holds the last granted index.
  - Search order is `rr_ptr+1, rr_ptr+2, …`, wrapping at N_CHILD-1 → 0.
  - The first child with valid high is granted, but only when the FIFO is not full.
- `child_ready` is combinational from `child_valid`, `rr_ptr` and the full flag. It is never asserted for a child whose valid is low.
- Transfer happens when `child_valid[i] & child_ready[i]`. On transfer, {i, payload} is pushed and `rr_ptr` ← i. With no transfer, `rr_ptr` holds.
- Children must hold valid and data stable until accepted. The block does not check this.
- FIFO behaviour:
  - Pop occurs when `evt_valid & evt_ready`.
  - `evt_valid` = level ≠ 0.
  - `evt_data` and `evt_src` come from the registered head entry. They are don't-care while `evt_valid` is low, but are driven to 0 after reset.
- Full condition: level == FIFO_DEPTH blocks all grants, even if a pop occurs in the same cycle. This is a deliberate simplification that costs one bubble.
- Simultaneous push and pop when not full: level is unchanged and ordering is preserved.
- Read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- Reset:
  - `rr_ptr` ← N_CHILD-1, so child 0 has first priority.
  - FIFO is emptied.
  - `fifo_level`=0, `evt_valid`=0, `evt_data`=0, `evt_src`=0, `child_ready`=0, `evt_count`=0.
- Reset asserted mid-operation discards all queued events. Children see ready low during reset and must re-present their events.

## Timing
- Grant-to-output latency: an event accepted in cycle t appears on `evt_valid` at cycle t+1 at the earliest.
- Throughput is one event per cycle in steady state while not full.
- From full with a pop in cycle t, grants resume at t+1.
- `fifo_level` updates on the clock edge after the push/pop.
- No combinational path from `evt_ready` to `child_ready`.

## Configuration
- `EVT_COUNT_EN` defined:
  - Adds the `evt_count` port and register.
  - The register increments by 1 on each pop and wraps 0xFFFF → 0x0000.
  - Reset value is 0.
- Not defined: port and register are absent. All other behaviour is identical.

## Structure
- Package `sb_event_pkg` holds:
  - Typedef `sb_evt_t` (struct {src, data}).
  - The SRC_W derivation function.
  - Default constants `SB_N_CHILD=5` and `SB_EVT_DATA_W=16`.
- Sub-module `sb_event_fifo`: synchronous FIFO with push/pop/full/empty/level, parameterized on depth and element type.
- Top-level keeps the arbiter and the counter.

## Test plan
- Single source: child 2 presents 0xA5A5 with parent ready → `child_ready`=5'b00100 in the same cycle; next cycle `evt_valid`=1, `evt_data`=0xA5A5, `evt_src`=2.
- Fairness: all five children valid continuously, parent always ready → grant order 0,1,2,3,4,0,… with one grant per cycle.
- Backpressure: `evt_ready`=0 with three children valid → exactly 4 accepts, `fifo_level`=4, `child_ready`=0 thereafter. Raising `evt_ready` for 1 cycle → grants resume the following cycle; order preserved on drain.
- Wrap: after reset only child 4 valid, then child 4 and child 0 valid → child 4 is granted first, then child 0 (pointer wraps 4→0).
- Reset mid-operation: FIFO holding 3 events, `rst` pulsed 1 cycle → `evt_valid`=0, `fifo_level`=0, `child_ready`=0 during reset; first post-reset grant goes to the lowest valid index.
- With EVT_COUNT_EN: 65537 pops → `evt_count`=1. Without the macro, the bench compiles with no `evt_count` port.

Source files
------------

// File: rtl/sb_event_pkg.sv
// sb_event_pkg: shared types, constants and helpers for the sb8-level event
// collector.
//   SB_N_CHILD, SB_EVT_DATA_W : default child count and payload width
//   sb_src_w()                : source-index width, max(1, $clog2(n))
//   sb_evt_t                  : {src, data} event word for the default config
package sb_event_pkg;

    localparam int unsigned SB_N_CHILD    = 5;
    localparam int unsigned SB_EVT_DATA_W = 16;

    function automatic int unsigned sb_src_w(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    localparam int unsigned SB_SRC_W = sb_src_w(SB_N_CHILD);

    typedef struct packed {
        logic [SB_SRC_W-1:0]      src;
        logic [SB_EVT_DATA_W-1:0] data;
    } sb_evt_t;

endpackage

// File: rtl/sb_event_fifo.sv
// sb_event_fifo: synchronous FIFO for event words.
//   clk, rst     : clock, synchronous active-high reset (empties, clears storage)
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : advance head (ignored when empty)
//   head_o       : registered head entry; reads 0 after reset
//   full_o       : level == DEPTH
//   empty_o      : level == 0
//   level_o      : current occupancy
module sb_event_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  T                 push_data_i,
    input  logic             pop_i,
    output T                 head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Storage is cleared so the head reads 0 right after reset.
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/sb_event_collector.sv
// sb_event_collector: round-robin collection of child events into a FIFO that
// drains to the parent, tagged with the source child index.
//   clk, rst     : clock, synchronous active-high reset
//   child_valid  : per-child event valid
//   child_data   : per-child payload, child i at [i*DATA_W +: DATA_W]
//   child_ready  : one-hot grant, zero when nothing is granted
//   evt_valid/evt_ready/evt_data/evt_src : head event toward the parent
//   fifo_level   : FIFO occupancy
//   evt_count    : delivered-event counter, only when EVT_COUNT_EN is defined
module sb_event_collector
    import sb_event_pkg::*;
#(
    parameter int unsigned N_CHILD    = SB_N_CHILD,
    parameter int unsigned DATA_W     = SB_EVT_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SRC_W     = sb_src_w(N_CHILD),
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CHILD-1:0]        child_valid,
    input  logic [N_CHILD*DATA_W-1:0] child_data,
    output logic [N_CHILD-1:0]        child_ready,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [DATA_W-1:0]         evt_data,
    output logic [SRC_W-1:0]          evt_src,
    output logic [LVL_W-1:0]          fifo_level
`ifdef EVT_COUNT_EN
    ,
    output logic [15:0]               evt_count
`endif
);

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [DATA_W-1:0] data;
    } evt_t;

    logic [SRC_W-1:0] rr_ptr_q;
    logic [SRC_W-1:0] rr_ptr_d;
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] cand;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_found;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    evt_t             push_evt;
    evt_t             head;

    // Search rr_ptr+1 .. rr_ptr+N_CHILD with wrap; full blocks every grant
    // regardless of a same-cycle pop, so evt_ready never reaches child_ready.
    always_comb begin
        sum         = '0;
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned off = 1; off <= N_CHILD; off++) begin
            sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(off);
            if (sum >= (SRC_W+1)'(N_CHILD)) begin
                sum = sum - (SRC_W+1)'(N_CHILD);
            end
            cand = sum[SRC_W-1:0];
            if (!grant_found && child_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        child_ready = '0;
        if (grant_found && !full && !rst) begin
            child_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        push_evt.src  = grant_idx;
        push_evt.data = '0;
        for (int unsigned i = 0; i < N_CHILD; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                push_evt.data = child_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign push     = |child_ready;
    assign pop      = evt_valid & evt_ready;
    assign rr_ptr_d = push ? grant_idx : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= SRC_W'(N_CHILD - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    sb_event_fifo #(
        .T     (evt_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_evt),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .level_o     (fifo_level)
    );

    assign evt_valid = ~empty;
    assign evt_data  = head.data;
    assign evt_src   = head.src;

`ifdef EVT_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d = pop ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign evt_count = cnt_q;
`endif

endmodule

// File: tb/tb_sb_event_collector.sv
module tb_sb_event_collector;
    import sb_event_pkg::*;

    localparam int N  = SB_N_CHILD;
    localparam int DW = SB_EVT_DATA_W;
    localparam int SW = SB_SRC_W;
    localparam int LW = $clog2(4) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    child_valid;
    logic [N*DW-1:0] child_data;
    logic [N-1:0]    child_ready;
    logic            evt_valid;
    logic            evt_ready;
    logic [DW-1:0]   evt_data;
    logic [SW-1:0]   evt_src;
    logic [LW-1:0]   fifo_level;
`ifdef EVT_COUNT_EN
    logic [15:0]     evt_count;
`endif

    sb_event_collector #(
        .N_CHILD    (N),
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .child_valid (child_valid),
        .child_data  (child_data),
        .child_ready (child_ready),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .evt_src     (evt_src),
        .fifo_level  (fifo_level)
`ifdef EVT_COUNT_EN
        ,
        .evt_count   (evt_count)
`endif
    );

    always #5 clk = ~clk;

    int      ntests = 0;
    int      nfail  = 0;
    sb_evt_t expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int src, input logic [15:0] data);
        sb_evt_t e;
        e.src  = SW'(src);
        e.data = data;
        expq.push_back(e);
    endtask

    // Monitor: every parent handshake pops one expected event.
    always @(negedge clk) begin
        sb_evt_t e;
        if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (expq.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_pop: got src %0d data 0x%0h, expected no event", evt_src, evt_data);
            end else begin
                e = expq.pop_front();
                chk("pop_src", 32'(evt_src), 32'(e.src));
                chk("pop_data", 32'(evt_data), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_child(input int i, input logic v, input logic [15:0] d);
        child_valid[i]          = v;
        child_data[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        step();
        rst         = 1'b1;
        child_valid = '0;
        evt_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        step();
        child_valid = '0;
        evt_ready   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (expq.size() == 0 && evt_valid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 32'(done), 32'd1);
        expq.delete();
    endtask

    initial begin
        int g[4];
        rst         = 1'b1;
        child_valid = '0;
        child_data  = '0;
        evt_ready   = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_data", 32'(evt_data), 32'd0);
        chk("rst_evt_src", 32'(evt_src), 32'd0);
        chk("rst_child_ready", 32'(child_ready), 32'd0);

        // Single source: child 2
        step();
        set_child(2, 1'b1, 16'hA5A5);
        evt_ready = 1'b1;
        @(negedge clk);
        chk("single_grant", 32'(child_ready), 32'b00100);
        push_exp(2, 16'hA5A5);
        step();
        child_valid = '0;
        @(negedge clk);
        chk("single_evt_valid", 32'(evt_valid), 32'd1);
        chk("single_level", 32'(fifo_level), 32'd1);
        drain();

        // Fairness: all children valid, parent always ready
        do_reset();
        for (int i = 0; i < N; i++) set_child(i, 1'b1, 16'(16'h1000 + i));
        evt_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("fair_grant", 32'(child_ready), 32'(1 << (k % 5)));
            push_exp(k % 5, 16'(16'h1000 + (k % 5)));
            step();
        end
        child_valid = '0;
        @(negedge clk);
        chk("fair_level", 32'(fifo_level), 32'd1);
        drain();

        // Backpressure: children 1,2,3 valid, parent stalled
        do_reset();
        for (int i = 1; i <= 3; i++) set_child(i, 1'b1, 16'(16'h2000 + i));
        evt_ready = 1'b0;
        g = '{1, 2, 3, 1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_grant", 32'(child_ready), 32'(1 << g[k]));
            push_exp(g[k], 16'(16'h2000 + g[k]));
            step();
        end
        @(negedge clk);
        chk("bp_full_level", 32'(fifo_level), 32'd4);
        chk("bp_full_ready", 32'(child_ready), 32'd0);
        step();
        @(negedge clk);
        chk("bp_hold_ready", 32'(child_ready), 32'd0);
        step();
        evt_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_blocks", 32'(child_ready), 32'd0);
        step();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_pop_level", 32'(fifo_level), 32'd3);
        chk("bp_resume_grant", 32'(child_ready), 32'b00100);
        push_exp(2, 16'h2002);
        step();
        @(negedge clk);
        chk("bp_refull_level", 32'(fifo_level), 32'd4);
        drain();

        // Wrap: child 4, then child 0 ahead of child 4 again
        do_reset();
        set_child(4, 1'b1, 16'h4444);
        evt_ready = 1'b1;
        @(negedge clk);
        chk("wrap_first", 32'(child_ready), 32'b10000);
        push_exp(4, 16'h4444);
        step();
        set_child(4, 1'b1, 16'h4445);
        set_child(0, 1'b1, 16'h0F0F);
        @(negedge clk);
        chk("wrap_second", 32'(child_ready), 32'b00001);
        push_exp(0, 16'h0F0F);
        step();
        set_child(0, 1'b0, 16'h0000);
        @(negedge clk);
        chk("wrap_third", 32'(child_ready), 32'b10000);
        push_exp(4, 16'h4445);
        drain();

        // Reset mid-operation with 3 queued events
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_child(i, 1'b1, 16'(16'h5000 + i));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_fill_grant", 32'(child_ready), 32'(1 << k));
            step();
        end
        child_valid = '0;
        set_child(1, 1'b1, 16'h5101);
        set_child(3, 1'b1, 16'h5303);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(child_ready), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_valid", 32'(evt_valid), 32'd0);
        chk("mid_post_level", 32'(fifo_level), 32'd0);
        chk("mid_post_data", 32'(evt_data), 32'd0);
        chk("mid_post_grant", 32'(child_ready), 32'b00010);
        push_exp(1, 16'h5101);
        step();
        set_child(1, 1'b0, 16'h0000);
        @(negedge clk);
        chk("mid_next_grant", 32'(child_ready), 32'b01000);
        push_exp(3, 16'h5303);
        drain();

`ifdef EVT_COUNT_EN
        // Delivered-event counter wraps after 65536 pops
        do_reset();
        @(negedge clk);
        chk("cnt_reset", 32'(evt_count), 32'd0);
        step();
        set_child(0, 1'b1, 16'h7777);
        evt_ready = 1'b1;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 70000; c++) begin
                @(negedge clk);
                if (child_ready[0] === 1'b1) begin
                    push_exp(0, 16'h7777);
                    n++;
                end
                step();
                if (n == 65537) break;
            end
            child_valid = '0;
            chk("cnt_pushes", 32'(n), 32'd65537);
        end
        drain();
        @(negedge clk);
        chk("cnt_wrap", 32'(evt_count), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
